lsu_mem_stage: RTL and testbench

//  Load/store stage placed directly downstream of the single-cycle core. It consumes ena_rd, ena_wr,
//  alu_out_ext and dataram_wr, and drives a req/ack data-memory bus. It returns datareg_wr, the

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_mem_stage_if.sv | 33 +++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_mem_stage.sv | 134 +++++++++++++
 tb/tb_lsu_mem_stage.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage.
// Provides the FSM state type, funct3 width codes and a funct3 legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_legal_f3(input logic [2:0] f3);
        return (f3 == F3_B)  || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Request/acknowledge data-memory bus between the LSU stage and memory.
// master: mem_req/we/addr/be/wdata out, mem_rdata/ack in; slave: reverse.
interface lsu_mem_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic shared by the store and load paths.
// In: i_funct3, i_off, i_wdata (rs2), i_rdata; out: o_be, o_wdata, o_rdata, o_misalign.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        unique case (i_off)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = i_wdata;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7] & ~i_funct3[2]}}, w_byte};
            end
            F3_H, F3_HU: begin
                o_be       = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{w_half[15] & ~i_funct3[2]}}, w_half};
                o_misalign = i_off[0];
            end
            F3_W: begin
                o_be       = 4'b1111;
                o_rdata    = i_rdata;
                o_misalign = |i_off;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: drives the req/ack memory bus, stalls the core, muxes write-back.
// Core side: ena_rd/ena_wr/MemtoReg/funct3/alu_out_ext/dataram_wr in; datareg_wr/stall/fault/bus_err out.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLOCK,
    input  logic              RST_n,
    input  logic              ena_rd,
    input  logic              ena_wr,
    input  logic              MemtoReg,
    input  logic [2:0]        funct3,
    input  logic [31:0]       alu_out_ext,
    input  logic [31:0]       dataram_wr,
    output logic [31:0]       datareg_wr,
    output logic              stall,
    output logic              fault,
    output logic              bus_err,
    lsu_mem_stage_if.master   mem
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata_q;
    logic [TW-1:0] r_tmo;
    logic        r_fault;
    logic        r_bus_err;

    logic        w_access;
    logic        w_bad;
    logic        w_go;
    logic        w_tmo_hit;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;
    logic        w_misalign;

    lsu_align u_align (
        .i_funct3   (funct3),
        .i_off      (alu_out_ext[1:0]),
        .i_wdata    (dataram_wr),
        .i_rdata    (r_rdata_q),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ldata),
        .o_misalign (w_misalign)
    );

    assign w_access  = ena_rd | ena_wr;
    assign w_bad     = w_misalign | ~is_legal_f3(funct3);
    assign w_go      = w_access & ~w_bad;
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        unique case (r_state)
            IDLE: begin
                stall = w_go;
                if (w_go) w_next = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (mem.mem_ack || w_tmo_hit) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_be      <= 4'b0000;
            r_wdata   <= 32'h0;
            r_rdata_q <= 32'h0;
            r_tmo     <= '0;
            r_fault   <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_fault   <= (r_state == IDLE) & w_access & w_bad;
            r_bus_err <= (r_state == WAIT) & ~mem.mem_ack & w_tmo_hit;
            if (r_state == IDLE && w_go) begin
                r_req   <= 1'b1;
                r_we    <= ena_wr;
                r_addr  <= {alu_out_ext[31:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_tmo   <= '0;
            end
            if (r_state == WAIT) begin
                if (mem.mem_ack) begin
                    r_req     <= 1'b0;
                    r_rdata_q <= mem.mem_rdata;
                end else if (w_tmo_hit) begin
                    // Timed-out loads return zero rather than stale data.
                    r_req     <= 1'b0;
                    r_rdata_q <= 32'h0;
                end else begin
                    r_tmo <= r_tmo + TW'(1);
                end
            end
        end
    end

    always_comb begin
        if (MemtoReg)
            datareg_wr = (r_state == DONE) ? w_ldata : 32'h0;
        else
            datareg_wr = alu_out_ext;
    end

    assign fault         = r_fault;
    assign bus_err       = r_bus_err;
    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage: loads, stores, faults, timeout, reset.
// Two instances: default timeout (A) and TIMEOUT_CYCLES=4 (B).
module tb_lsu_mem_stage;

    logic        CLOCK = 1'b0;
    logic        RST_n = 1'b0;
    logic        ena_rd = 1'b0;
    logic        ena_wr = 1'b0;
    logic        b_rd = 1'b0;
    logic        b_wr = 1'b0;
    logic        MemtoReg = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu = 32'h0;
    logic [31:0] wd = 32'h0;

    logic [31:0] a_dreg, b_dreg;
    logic        a_stall, b_stall;
    logic        a_fault, b_fault;
    logic        a_berr, b_berr;

    int n_tests = 0;
    int n_fail  = 0;
    int scyc, rcyc;

    lsu_mem_stage_if ifa ();
    lsu_mem_stage_if ifb ();

    lsu_mem_stage dut_a (
        .CLOCK       (CLOCK),
        .RST_n       (RST_n),
        .ena_rd      (ena_rd),
        .ena_wr      (ena_wr),
        .MemtoReg    (MemtoReg),
        .funct3      (funct3),
        .alu_out_ext (alu),
        .dataram_wr  (wd),
        .datareg_wr  (a_dreg),
        .stall       (a_stall),
        .fault       (a_fault),
        .bus_err     (a_berr),
        .mem         (ifa)
    );

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut_b (
        .CLOCK       (CLOCK),
        .RST_n       (RST_n),
        .ena_rd      (b_rd),
        .ena_wr      (b_wr),
        .MemtoReg    (MemtoReg),
        .funct3      (funct3),
        .alu_out_ext (alu),
        .dataram_wr  (wd),
        .datareg_wr  (b_dreg),
        .stall       (b_stall),
        .fault       (b_fault),
        .bus_err     (b_berr),
        .mem         (ifb)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK);
        #2;
    endtask

    // Drive one access on A; ack in stall-cycle index nwait (0 = IDLE).
    task automatic acc_a(input logic rd, input logic wr, input logic m2r,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdat, input int nwait,
                         input logic [31:0] rdat,
                         output int sc, output int rc);
        ena_rd = rd; ena_wr = wr; MemtoReg = m2r;
        funct3 = f3; alu = addr; wd = wdat;
        #1;
        sc = 0; rc = 0;
        for (int c = 0; c < 40; c++) begin
            if (!a_stall) break;
            sc++;
            if (ifa.mem_req) rc++;
            if (c == nwait) begin
                ifa.mem_ack = 1'b1;
                ifa.mem_rdata = rdat;
            end
            tick;
            ifa.mem_ack = 1'b0;
            ifa.mem_rdata = 32'h0;
        end
    endtask

    task automatic retire_a;
        ena_rd = 1'b0; ena_wr = 1'b0;
        tick;
    endtask

    initial begin
        ifa.mem_ack = 1'b0; ifa.mem_rdata = 32'h0;
        ifb.mem_ack = 1'b0; ifb.mem_rdata = 32'h0;

        // Reset state
        #1;
        chk("rst_req", {31'h0, ifa.mem_req}, 32'h0);
        chk("rst_be", {28'h0, ifa.mem_be}, 32'h0);
        chk("rst_addr", ifa.mem_addr, 32'h0);
        chk("rst_fault", {31'h0, a_fault}, 32'h0);
        chk("rst_berr", {31'h0, a_berr}, 32'h0);
        chk("rst_stall", {31'h0, a_stall}, 32'h0);
        chk("rst_dreg", a_dreg, 32'h0);
        @(negedge CLOCK);
        RST_n = 1'b1;
        tick;

        // 1. LW @0x100, ack at first WAIT cycle
        acc_a(1, 0, 1, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, scyc, rcyc);
        chk("lw_stall_cyc", scyc, 2);
        chk("lw_req_cyc", rcyc, 1);
        chk("lw_addr", ifa.mem_addr, 32'h100);
        chk("lw_be", {28'h0, ifa.mem_be}, 32'hF);
        chk("lw_we", {31'h0, ifa.mem_we}, 32'h0);
        chk("lw_req_done", {31'h0, ifa.mem_req}, 32'h0);
        chk("lw_dreg", a_dreg, 32'hDEADBEEF);
        retire_a;
        chk("lw_idle_dreg", a_dreg, 32'h0);

        // 2. LB / LBU @0x103 ; LH / LHU @0x102
        acc_a(1, 0, 1, 3'b000, 32'h103, 32'h0, 1, 32'h80123456, scyc, rcyc);
        chk("lb_addr", ifa.mem_addr, 32'h100);
        chk("lb_dreg", a_dreg, 32'hFFFFFF80);
        retire_a;
        acc_a(1, 0, 1, 3'b100, 32'h103, 32'h0, 1, 32'h80123456, scyc, rcyc);
        chk("lbu_dreg", a_dreg, 32'h00000080);
        retire_a;
        acc_a(1, 0, 1, 3'b001, 32'h102, 32'h0, 2, 32'h8001FFFF, scyc, rcyc);
        chk("lh_stall_cyc", scyc, 3);
        chk("lh_dreg", a_dreg, 32'hFFFF8001);
        retire_a;
        acc_a(1, 0, 1, 3'b101, 32'h102, 32'h0, 1, 32'h8001FFFF, scyc, rcyc);
        chk("lhu_dreg", a_dreg, 32'h00008001);
        retire_a;

        // 3. SH @0x102, ack after 5 WAIT cycles; SB @0x101
        acc_a(0, 1, 0, 3'b001, 32'h102, 32'h1234ABCD, 5, 32'h0, scyc, rcyc);
        chk("sh_stall_cyc", scyc, 6);
        chk("sh_req_cyc", rcyc, 5);
        chk("sh_we", {31'h0, ifa.mem_we}, 32'h1);
        chk("sh_be", {28'h0, ifa.mem_be}, 32'hC);
        chk("sh_wdata", ifa.mem_wdata, 32'hABCDABCD);
        chk("sh_addr", ifa.mem_addr, 32'h100);
        chk("sh_dreg", a_dreg, 32'h102);
        retire_a;
        acc_a(0, 1, 0, 3'b000, 32'h101, 32'h0000005A, 1, 32'h0, scyc, rcyc);
        chk("sb_be", {28'h0, ifa.mem_be}, 32'h2);
        chk("sb_wdata", ifa.mem_wdata, 32'h5A5A5A5A);
        retire_a;

        // 4. Misaligned LW and illegal funct3
        ena_rd = 1'b1; MemtoReg = 1'b1; funct3 = 3'b010; alu = 32'h101;
        #1;
        chk("mis_stall", {31'h0, a_stall}, 32'h0);
        chk("mis_dreg", a_dreg, 32'h0);
        tick;
        chk("mis_fault", {31'h0, a_fault}, 32'h1);
        chk("mis_req", {31'h0, ifa.mem_req}, 32'h0);
        ena_rd = 1'b0;
        tick;
        chk("mis_fault_end", {31'h0, a_fault}, 32'h0);
        ena_rd = 1'b1; funct3 = 3'b011; alu = 32'h100;
        #1;
        chk("ill_stall", {31'h0, a_stall}, 32'h0);
        chk("ill_dreg", a_dreg, 32'h0);
        tick;
        chk("ill_fault", {31'h0, a_fault}, 32'h1);
        chk("ill_req", {31'h0, ifa.mem_req}, 32'h0);
        ena_rd = 1'b0;
        tick;
        chk("ill_fault_end", {31'h0, a_fault}, 32'h0);

        // 5. Timeout on B (TIMEOUT_CYCLES=4), SW with no ack
        b_wr = 1'b1; MemtoReg = 1'b0; funct3 = 3'b010;
        alu = 32'h200; wd = 32'hCAFEF00D;
        #1;
        chk("tmo_stall_idle", {31'h0, b_stall}, 32'h1);
        tick;
        rcyc = 0;
        for (int c = 0; c < 20; c++) begin
            if (ifb.mem_req) rcyc++;
            if (b_berr) break;
            tick;
        end
        chk("tmo_req_cyc", rcyc, 4);
        chk("tmo_berr", {31'h0, b_berr}, 32'h1);
        chk("tmo_stall_done", {31'h0, b_stall}, 32'h0);
        chk("tmo_be", {28'h0, ifb.mem_be}, 32'hF);
        chk("tmo_wdata", ifb.mem_wdata, 32'hCAFEF00D);
        chk("tmo_we", {31'h0, ifb.mem_we}, 32'h1);
        b_wr = 1'b0;
        tick;
        chk("tmo_berr_end", {31'h0, b_berr}, 32'h0);
        chk("tmo_req_idle", {31'h0, ifb.mem_req}, 32'h0);

        // 6. Async reset while A waits
        ena_rd = 1'b1; MemtoReg = 1'b1; funct3 = 3'b010; alu = 32'h300;
        #1;
        tick;
        chk("rw_req", {31'h0, ifa.mem_req}, 32'h1);
        tick;
        #1;
        RST_n = 1'b0;
        #1;
        chk("rw_req_async", {31'h0, ifa.mem_req}, 32'h0);
        ena_rd = 1'b0;
        @(negedge CLOCK);
        RST_n = 1'b1;
        tick;
        chk("rw_req_after", {31'h0, ifa.mem_req}, 32'h0);
        chk("rw_stall_after", {31'h0, a_stall}, 32'h0);

        // Non-memory instruction
        MemtoReg = 1'b0; alu = 32'h13572468;
        #1;
        chk("alu_dreg", a_dreg, 32'h13572468);
        chk("alu_stall", {31'h0, a_stall}, 32'h0);

        // Access after reset works from IDLE
        acc_a(1, 0, 1, 3'b010, 32'h104, 32'h0, 1, 32'h0BADF00D, scyc, rcyc);
        chk("post_stall_cyc", scyc, 2);
        chk("post_addr", ifa.mem_addr, 32'h104);
        chk("post_dreg", a_dreg, 32'h0BADF00D);
        retire_a;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
